alu_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares the single combinational ALU between two requesters, such as a fetch/branch-compare path and the execute path. It accepts one operation at a time through a valid/ready handshake. It drives the ALU operand and opcode lines from registers, captures the result and zero flag one cycle later, and returns them with the requester ID through a valid/ready response channel. It also flags unsupported opcodes and keeps per-port completion counters.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A single
// operation is in flight at a time: it is accepted in IDLE, its operands
// are driven to the ALU from registers during EXEC, and the captured result
// is offered on the response channel in RESP until the consumer takes it.
// When both ports ask at once, the port that was not served last wins.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready              request handshake for port N (0 or 1)
//   reqN_opcode, reqN_a, reqN_b   operation for port N
//   alu_opcode, alu_a, alu_b      registered operation driven to the ALU
//   alu_result, alu_zero          combinational ALU outputs
//   resp_valid/ready              response handshake
//   resp_id, resp_result,
//   resp_zero, resp_err           response payload (err = illegal opcode)
//   busy                          FSM not in IDLE
//   done_cnt0, done_cnt1          per-port completed response counters
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic [3:0]       alu_opcode,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [3:0]         alu_opcode_q, alu_opcode_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic               resp_id_q, resp_id_d;
  logic [31:0]        resp_result_q, resp_result_d;
  logic               resp_zero_q, resp_zero_d;
  logic               resp_err_q, resp_err_d;
  logic [CNT_W-1:0]   done_cnt0_q, done_cnt0_d;
  logic [CNT_W-1:0]   done_cnt1_q, done_cnt1_d;
  logic               accept0, accept1;

  // A port is blocked only when the other port also wants service and the
  // blocked port was the one served last. The readies deliberately ignore
  // the port's own valid so a requester can see acceptance ahead of time.
  always_comb begin
    req0_ready = (state_q == IDLE) && !(req1_valid && (last_q == 1'b0));
    req1_ready = (state_q == IDLE) && !(req0_valid && (last_q == 1'b1));
    accept0    = req0_valid && req0_ready;
    accept1    = req1_valid && req1_ready;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    alu_opcode_d  = alu_opcode_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;
    done_cnt0_d   = done_cnt0_q;
    done_cnt1_d   = done_cnt1_q;
    case (state_q)
      IDLE: begin
        if (accept0) begin
          alu_opcode_d = req0_opcode;
          alu_a_d      = req0_a;
          alu_b_d      = req0_b;
          resp_id_d    = 1'b0;
          state_d      = EXEC;
        end else if (accept1) begin
          alu_opcode_d = req1_opcode;
          alu_a_d      = req1_a;
          alu_b_d      = req1_b;
          resp_id_d    = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // Opcodes 9..15 have no ALU meaning, so whatever the ALU drives is
        // discarded and a fixed zero result is reported instead.
        if (alu_opcode_q > 4'd8) begin
          resp_result_d = 32'd0;
          resp_zero_d   = 1'b1;
          resp_err_d    = 1'b1;
        end else begin
          resp_result_d = alu_result;
          resp_zero_d   = alu_zero;
          resp_err_d    = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          last_d = resp_id_q;
          if (resp_id_q) begin
            done_cnt1_d = done_cnt1_q + CNT_W'(1);
          end else begin
            done_cnt0_d = done_cnt0_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      alu_opcode_q  <= 4'd0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 32'd0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      done_cnt0_q   <= '0;
      done_cnt1_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
      done_cnt0_q   <= done_cnt0_d;
      done_cnt1_q   <= done_cnt1_d;
    end
  end

  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign resp_valid  = (state_q == RESP);
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != IDLE);
  assign done_cnt0   = done_cnt0_q;
  assign done_cnt1   = done_cnt1_q;

endmodule
